instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 73 +++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues ROM byte addresses, replays the in-flight address
// while decode stalls, and restarts at a word-aligned target on redirect.
module instruction_fetch #(
  parameter int unsigned     SIZE     = 32,
  parameter int unsigned     INSTR_W  = 48,
  parameter logic [SIZE-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [SIZE-1:0]    RedirectPC,
  output logic [SIZE-1:0]    RomAddr,
  input  logic [INSTR_W-1:0] RomInstr,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [SIZE-1:0]    PCOut,
  output logic               Valid,
  output logic [31:0]        FetchCount
);

  localparam int unsigned CNT_W = 32;

  logic [SIZE-1:0]  fetch_pc;
  logic [SIZE-1:0]  out_pc;
  logic             out_valid;
  logic [CNT_W-1:0] fetch_count;
  logic [SIZE-1:0]  target_pc;
  logic             accept;

  // Low two bits of the redirect target are dropped to keep fetches word aligned.
  assign target_pc = RedirectPC & ~SIZE'(3);

  // An instruction is consumed by decode only when nothing holds or squashes it.
  assign accept = out_valid && !Stall && !Redirect;

  always_comb begin
    RomAddr = fetch_pc;
    if (Redirect) begin
      RomAddr = target_pc;
    end else if (Stall && out_valid) begin
      RomAddr = out_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fetch_pc    <= RESET_PC;
      out_pc      <= '0;
      out_valid   <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (Redirect) begin
        out_pc    <= target_pc;
        out_valid <= 1'b1;
        fetch_pc  <= target_pc + SIZE'(PC_STEP);
      end else if (!Stall) begin
        out_pc    <= fetch_pc;
        out_valid <= 1'b1;
        fetch_pc  <= fetch_pc + SIZE'(PC_STEP);
      end
      if (accept && (fetch_count != {CNT_W{1'b1}})) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  assign PCOut      = out_pc;
  assign Valid      = out_valid;
  assign InstrOut   = out_valid ? RomInstr : '0;
  assign FetchCount = fetch_count;

endmodule
